sqrt_output_wrapper: RTL and testbench
======================================

// Module: sqrt_output_wrapper
// PURPOSE
//  Result-side counterpart of the sqrt input-wrapper controller. Arms on start_sqrt, waits
//  for the sqrt core's done pulse, captures the root, rounds to nearest-even, applies the
//  exponent and special-case rules, and holds a packed IEEE-754 single until acknowledged.
//  Also reports a watchdog timeout if the core never answers.
// PARAMETERS
//  MANT_W   23  stored mantissa width
//  EXP_W    8   exponent width; bias = 2^(EXP_W-1)-1 (127)
//  ROOT_W   25  core root width: {hidden 1, MANT_W fraction, 1 guard}
//  TIMEOUT  64  max WAIT cycles before timeout (>=2)
// PORTS
//  clk          in   1       clock, rising edge
//  rst          in   1       asynchronous reset, active-high
//  start_sqrt   in   1       1-cycle start pulse, same one the input side sends to the core
//  sign_in      in   1       operand sign, sampled with start_sqrt
//  exp_in       in   EXP_W   operand biased exponent, sampled with start_sqrt
//  is_nan       in   1       operand is NaN, sampled with start_sqrt
//  is_inf       in   1       operand is infinity, sampled with start_sqrt
//  sqrt_done    in   1       1-cycle done pulse from sqrt core
//  root         in   ROOT_W  core root, valid when sqrt_done=1
//  rem_nz       in   1       core remainder nonzero (sticky), valid with sqrt_done
//  result       out  32      packed float {sign, EXP_W exponent, MANT_W mantissa}
//  result_valid out  1       result is held stable while this is high
//  result_ack   in   1       consumer accepts result
//  busy         out  1       high in WAIT/ROUND/HOLD
//  timeout_err  out  1       last operation timed out; sticky until next accepted start
// BEHAVIOUR
//  Reset: state IDLE, result=0, result_valid=0, busy=0, timeout_err=0, wait counter=0.
//    Reset mid-operation discards all pending state; a later sqrt_done in IDLE is ignored.
//  FSM: IDLE, WAIT, ROUND, HOLD; all outputs registered.
//  IDLE: start_sqrt=1 -> latch sign/exp/flags, clear timeout_err, counter=0, go WAIT.
//    sqrt_done in IDLE is ignored.
//  WAIT: sqrt_done=1 -> latch root/rem_nz, go ROUND. Otherwise counter++; when the counter
//    reaches TIMEOUT-1 without done -> result=0x7FC00000, timeout_err=1, go HOLD.
//    start_sqrt is ignored in WAIT, ROUND and HOLD.
//  ROUND (1 cycle): compute and register result, go HOLD. result_valid=1 from the first HOLD
//    cycle, i.e. 2 cycles after the cycle where sqrt_done is sampled.
//  Exponent: e = exp_in - bias (signed); out_exp = (e >>> 1) + bias, arithmetic shift (floor).
//    Example: exp_in 126 -> 126.
//  Mantissa: m = root[ROOT_W-2:1], G = root[0], S = rem_nz. Increment m iff
//    G & (S | m[0]). If the increment carries out: m=0, out_exp+1.
//  Specials (override the core root; sqrt_done is still awaited to keep protocol aligned):
//    - NaN, or sign=1 with a nonzero operand -> 0x7FC00000.
//    - +inf -> 0x7F800000.
//    - exp_in=0 (zero or denormal, flushed to zero) -> {sign_in, 31'b0}.
//    - Priority: NaN > zero > negative > inf.
//  HOLD: result and result_valid stay stable until result_ack=1; that cycle -> IDLE, and
//    result_valid drops on the next edge. result keeps its value after that.
//    start_sqrt arriving in the same cycle as the ack is ignored.
//  timeout_err holds until the next start_sqrt accepted in IDLE.
// TESTING
//  1. sqrt(4.0): exp_in=129, sign 0; done 3 cycles later, root=25'h1000000, rem_nz=0
//     -> result 0x40000000, valid exactly 2 cycles after done.
//  2. sqrt(2.0): exp_in=128, root={1'b1,23'h3504F3,1'b0}, rem_nz=1 -> 0x3FB504F3.
//     Also sqrt(0.5): exp_in=126, same root -> 0x3F3504F3.
//  3. Rounding: m=23'h000002, G=1, S=0 -> mantissa 0x000002 (tie, even, no increment).
//     m=23'h000003, G=1, S=0 -> 0x000004. m=all ones, G=1, S=1 -> m=0, exponent+1.
//  4. Specials: sign=1, exp_in=130 -> 0x7FC00000. is_inf, sign 0 -> 0x7F800000.
//     exp_in=0, sign 1 -> 0x80000000. Each only after sqrt_done.
//  5. No sqrt_done for TIMEOUT cycles -> 0x7FC00000 with timeout_err=1 and busy high until ack.
//     Next start clears timeout_err.
//  6. Hold ack low 5 cycles with start_sqrt pulses during HOLD -> result stable, starts ignored.
//     Assert rst mid-WAIT, then send sqrt_done -> outputs stay at reset values.

Source files
------------

// File: rtl/sqrt_output_wrapper.sv
// Result side of the sqrt controller: waits for the core, rounds the root to nearest-even,
// applies exponent halving and special-case rules, and holds a packed float until acked.
module sqrt_output_wrapper #(
    parameter int MANT_W  = 23,
    parameter int EXP_W   = 8,
    parameter int ROOT_W  = 25,
    parameter int TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_sqrt,
    input  logic                    sign_in,
    input  logic [EXP_W-1:0]        exp_in,
    input  logic                    is_nan,
    input  logic                    is_inf,
    input  logic                    sqrt_done,
    input  logic [ROOT_W-1:0]       root,
    input  logic                    rem_nz,
    output logic [EXP_W+MANT_W:0]   result,
    output logic                    result_valid,
    input  logic                    result_ack,
    output logic                    busy,
    output logic                    timeout_err
);

    localparam int RES_W = 1 + EXP_W + MANT_W;
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [EXP_W-1:0] BIAS     = EXP_W'((1 << (EXP_W - 1)) - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [RES_W-1:0] QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};
    localparam logic [RES_W-1:0] PINF     = {1'b0, {EXP_W{1'b1}}, {MANT_W{1'b0}}};

    typedef enum logic [1:0] {IDLE, WAIT, ROUND, HOLD} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                sign_q, nan_q, inf_q, rem_q;
    logic [EXP_W-1:0]    exp_q;
    logic [ROOT_W-2:0]   root_q;
    logic                latch_op, latch_root, timeout_d;
    logic [RES_W-1:0]    result_d, rounded;

    logic signed [EXP_W-1:0] e_unb, e_half;
    logic [MANT_W-1:0]       m;
    logic                    inc;
    logic [MANT_W:0]         m_sum;
    logic [EXP_W-1:0]        exp_out;

    // The unbiased exponent fits EXP_W signed bits for every non-special operand,
    // so halving is done modulo 2^EXP_W and rebiased.
    always_comb begin
        e_unb   = $signed(exp_q - BIAS);
        e_half  = e_unb >>> 1;
        m       = root_q[ROOT_W-2:1];
        inc     = root_q[0] & (rem_q | m[0]);
        m_sum   = {1'b0, m} + {{MANT_W{1'b0}}, inc};
        exp_out = $unsigned(e_half) + BIAS + {{(EXP_W-1){1'b0}}, m_sum[MANT_W]};

        if (nan_q)
            rounded = QNAN;
        else if (exp_q == '0)
            rounded = {sign_q, {(RES_W-1){1'b0}}};
        else if (sign_q)
            rounded = QNAN;
        else if (inf_q)
            rounded = PINF;
        else
            rounded = {1'b0, exp_out, m_sum[MANT_W-1:0]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        timeout_d  = timeout_err;
        result_d   = result;
        latch_op   = 1'b0;
        latch_root = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_sqrt) begin
                    latch_op  = 1'b1;
                    timeout_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (sqrt_done) begin
                    latch_root = 1'b1;
                    state_d    = ROUND;
                end else if (cnt_q == CNT_LAST) begin
                    result_d  = QNAN;
                    timeout_d = 1'b1;
                    state_d   = HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ROUND: begin
                result_d = rounded;
                state_d  = HOLD;
            end
            HOLD: begin
                if (result_ack)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            sign_q       <= 1'b0;
            exp_q        <= '0;
            nan_q        <= 1'b0;
            inf_q        <= 1'b0;
            root_q       <= '0;
            rem_q        <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            result       <= result_d;
            timeout_err  <= timeout_d;
            result_valid <= (state_d == HOLD);
            busy         <= (state_d != IDLE);
            if (latch_op) begin
                sign_q <= sign_in;
                exp_q  <= exp_in;
                nan_q  <= is_nan;
                inf_q  <= is_inf;
            end
            if (latch_root) begin
                root_q <= root[ROOT_W-2:0];
                rem_q  <= rem_nz;
            end
        end
    end

endmodule

// File: tb/tb_sqrt_output_wrapper.sv
// Randomized and directed check of sqrt_output_wrapper against an arithmetic reference model.
module tb_sqrt_output_wrapper;

    localparam int MANT_W  = 23;
    localparam int EXP_W   = 8;
    localparam int ROOT_W  = 25;
    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_sqrt = 1'b0;
    logic        sign_in = 1'b0;
    logic [7:0]  exp_in = '0;
    logic        is_nan = 1'b0;
    logic        is_inf = 1'b0;
    logic        sqrt_done = 1'b0;
    logic [24:0] root = '0;
    logic        rem_nz = 1'b0;
    logic [31:0] result;
    logic        result_valid;
    logic        result_ack = 1'b0;
    logic        busy;
    logic        timeout_err;

    int total = 0;
    int bad   = 0;

    sqrt_output_wrapper #(
        .MANT_W (MANT_W),
        .EXP_W  (EXP_W),
        .ROOT_W (ROOT_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_sqrt  (start_sqrt),
        .sign_in     (sign_in),
        .exp_in      (exp_in),
        .is_nan      (is_nan),
        .is_inf      (is_inf),
        .sqrt_done   (sqrt_done),
        .root        (root),
        .rem_nz      (rem_nz),
        .result      (result),
        .result_valid(result_valid),
        .result_ack  (result_ack),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, want);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Reference: real-number view of sqrt result (floor-halved exponent, RNE on the root).
    function automatic logic [31:0] model(input logic s, input logic [7:0] e, input logic n,
                                          input logic i, input logic [24:0] r, input logic rn);
        int eu, half, oexp, q;
        logic [7:0] oe;
        logic [31:0] qv;
        if (n) return 32'h7FC00000;
        if (e == 0) return {s, 31'b0};
        if (s) return 32'h7FC00000;
        if (i) return 32'h7F800000;
        eu   = int'(e) - 127;
        half = (eu >= 0) ? eu / 2 : -((1 - eu) / 2);
        oexp = half + 127;
        q    = int'(r >> 1);
        if (r[0] && (rn || (q % 2 == 1))) q = q + 1;
        if (q >= (1 << 24)) begin
            q    = q / 2;
            oexp = oexp + 1;
        end
        oe = oexp[7:0];
        qv = q;
        return {1'b0, oe, qv[22:0]};
    endfunction

    task automatic scramble;
        sign_in = 1'($urandom);
        exp_in  = 8'($urandom);
        is_nan  = 1'($urandom);
        is_inf  = 1'($urandom);
        root    = 25'($urandom);
        rem_nz  = 1'($urandom);
    endtask

    task automatic run_op(input string tag, input logic s, input logic [7:0] e, input logic n,
                          input logic i, input logic [24:0] r, input logic rn,
                          input logic [31:0] want, input int dly, input int hold,
                          input bit noise, input bit start_with_ack);
        start_sqrt = 1'b1;
        sign_in = s; exp_in = e; is_nan = n; is_inf = i;
        step;
        start_sqrt = 1'b0;
        scramble;
        check_eq({tag, ".busy"}, 32'(busy), 32'd1);
        for (int k = 0; k < dly; k++) begin
            check_eq({tag, ".wait_valid"}, 32'(result_valid), 32'd0);
            if (noise) start_sqrt = 1'($urandom);
            step;
        end
        start_sqrt = 1'b0;
        sqrt_done = 1'b1; root = r; rem_nz = rn;
        step;
        sqrt_done = 1'b0;
        root = 25'($urandom); rem_nz = 1'($urandom);
        check_eq({tag, ".round_valid"}, 32'(result_valid), 32'd0);
        step;
        check_eq({tag, ".valid"}, 32'(result_valid), 32'd1);
        check_eq({tag, ".result"}, result, want);
        check_eq({tag, ".busy_hold"}, 32'(busy), 32'd1);
        for (int k = 0; k < hold; k++) begin
            if (noise) start_sqrt = 1'($urandom);
            step;
            check_eq({tag, ".hold_result"}, result, want);
            check_eq({tag, ".hold_valid"}, 32'(result_valid), 32'd1);
        end
        result_ack = 1'b1;
        start_sqrt = start_with_ack;
        step;
        result_ack = 1'b0;
        start_sqrt = 1'b0;
        check_eq({tag, ".ack_valid"}, 32'(result_valid), 32'd0);
        check_eq({tag, ".keep_result"}, result, want);
        step;
        check_eq({tag, ".idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic        s, n, i, rn;
        logic [7:0]  e;
        logic [24:0] r;
        int          kind;

        #12;
        check_eq("reset.result", result, 32'h0);
        check_eq("reset.valid", 32'(result_valid), 32'd0);
        check_eq("reset.busy", 32'(busy), 32'd0);
        check_eq("reset.timeout", 32'(timeout_err), 32'd0);
        rst = 1'b0;
        step;

        // sqrt_done while idle must not do anything
        sqrt_done = 1'b1; root = 25'h1FFFFFF;
        step;
        sqrt_done = 1'b0;
        step;
        check_eq("idle_done.valid", 32'(result_valid), 32'd0);
        check_eq("idle_done.busy", 32'(busy), 32'd0);

        run_op("sqrt4", 0, 8'd129, 0, 0, 25'h1000000, 0, 32'h40000000, 2, 0, 0, 0);
        run_op("sqrt2", 0, 8'd128, 0, 0, {1'b1, 23'h3504F3, 1'b0}, 1, 32'h3FB504F3, 1, 0, 0, 0);
        run_op("sqrt05", 0, 8'd126, 0, 0, {1'b1, 23'h3504F3, 1'b0}, 1, 32'h3F3504F3, 0, 0, 0, 0);
        run_op("tie_even", 0, 8'd127, 0, 0, {1'b1, 23'h000002, 1'b1}, 0, 32'h3F800002, 0, 0, 0, 0);
        run_op("tie_odd", 0, 8'd127, 0, 0, {1'b1, 23'h000003, 1'b1}, 0, 32'h3F800004, 0, 0, 0, 0);
        run_op("carry", 0, 8'd127, 0, 0, {1'b1, 23'h7FFFFF, 1'b1}, 1, 32'h40000000, 0, 0, 0, 0);
        run_op("neg", 1, 8'd130, 0, 0, 25'h1234567, 0, 32'h7FC00000, 4, 0, 0, 0);
        run_op("pinf", 0, 8'd255, 0, 1, 25'h1000000, 0, 32'h7F800000, 3, 0, 0, 0);
        run_op("negzero", 1, 8'd0, 0, 0, 25'h1555555, 1, 32'h80000000, 2, 0, 0, 0);
        run_op("nan", 1, 8'd255, 1, 1, 25'h1000000, 0, 32'h7FC00000, 1, 0, 0, 0);
        run_op("hold5", 0, 8'd131, 0, 0, {1'b1, 23'h12345, 1'b0}, 0,
               model(0, 8'd131, 0, 0, {1'b1, 23'h12345, 1'b0}, 0), 3, 5, 1, 1);

        // Watchdog: no done for TIMEOUT wait cycles
        start_sqrt = 1'b1; sign_in = 0; exp_in = 8'd140; is_nan = 0; is_inf = 0;
        step;
        start_sqrt = 1'b0;
        for (int k = 1; k < TIMEOUT; k++) step;
        check_eq("to.pre_valid", 32'(result_valid), 32'd0);
        check_eq("to.pre_err", 32'(timeout_err), 32'd0);
        step;
        check_eq("to.valid", 32'(result_valid), 32'd1);
        check_eq("to.result", result, 32'h7FC00000);
        check_eq("to.err", 32'(timeout_err), 32'd1);
        for (int k = 0; k < 3; k++) begin
            step;
            check_eq("to.busy", 32'(busy), 32'd1);
        end
        result_ack = 1'b1;
        step;
        result_ack = 1'b0;
        step;
        check_eq("to.err_sticky", 32'(timeout_err), 32'd1);
        start_sqrt = 1'b1; exp_in = 8'd129;
        step;
        start_sqrt = 1'b0;
        check_eq("to.err_cleared", 32'(timeout_err), 32'd0);
        sqrt_done = 1'b1; root = 25'h1000000; rem_nz = 0;
        step;
        sqrt_done = 1'b0;
        step;
        check_eq("to.next_result", result, 32'h40000000);
        result_ack = 1'b1;
        step;
        result_ack = 1'b0;
        step;

        for (int t = 0; t < 40; t++) begin
            kind = $urandom_range(0, 9);
            s = 0; n = 0; i = 0;
            e = 8'($urandom_range(1, 254));
            r = {1'b1, 24'($urandom)};
            rn = 1'($urandom);
            case (kind)
                0: n = 1;
                1: begin s = 1'($urandom); e = 0; end
                2: s = 1;
                3: begin i = 1; e = 8'd255; end
                default: ;
            endcase
            run_op("rand", s, e, n, i, r, rn, model(s, e, n, i, r, rn),
                   $urandom_range(0, 10), $urandom_range(0, 3), 1'($urandom), 1'($urandom));
        end

        // Reset in the middle of WAIT, followed by a stray done
        start_sqrt = 1'b1; exp_in = 8'd129; sign_in = 0;
        step;
        start_sqrt = 1'b0;
        step; step;
        rst = 1'b1;
        #2;
        check_eq("rst_mid.busy", 32'(busy), 32'd0);
        check_eq("rst_mid.result", result, 32'h0);
        step;
        rst = 1'b0;
        sqrt_done = 1'b1; root = 25'h1000000;
        step;
        sqrt_done = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step;
            check_eq("rst_mid.valid", 32'(result_valid), 32'd0);
            check_eq("rst_mid.idle", 32'(busy), 32'd0);
            check_eq("rst_mid.res", result, 32'h0);
            check_eq("rst_mid.err", 32'(timeout_err), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got=stuck want=finish");
        $fatal(1, "simulation time limit");
    end

endmodule
